// File: rtl/sync_debounce_edge.sv
// sync_debounce_edge: per-channel synchroniser, stability filter and registered edge detector
//   iw_clk      single clock for all logic
//   iw_rst      asynchronous active-high reset
//   iwv_input   raw asynchronous inputs, one bit per channel
//   owv_output  synchronised, debounced level per channel
//   owv_rise    one-cycle pulse when owv_output goes 0->1
//   owv_fall    one-cycle pulse when owv_output goes 1->0
//   ow_any_edge OR of all rise/fall pulses
module sync_debounce_edge #(
  parameter int p_WIDTH = 1,
  parameter int p_DEPTH = 2,
  parameter int p_FILTER_CYCLES = 1,
  parameter logic [p_WIDTH-1:0] p_INIT_VALUE = '0
) (
  input  logic               iw_clk,
  input  logic               iw_rst,
  input  logic [p_WIDTH-1:0] iwv_input,
  output logic [p_WIDTH-1:0] owv_output,
  output logic [p_WIDTH-1:0] owv_rise,
  output logic [p_WIDTH-1:0] owv_fall,
  output logic               ow_any_edge
);
  localparam int cnt_w = p_FILTER_CYCLES > 1 ? $clog2(p_FILTER_CYCLES) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(p_FILTER_CYCLES - 1);
  if (p_DEPTH < 2) begin : g_depth_chk
    $error("p_DEPTH must be at least 2");
  end
  if (p_FILTER_CYCLES < 1) begin : g_filter_chk
    $error("p_FILTER_CYCLES must be at least 1");
  end
  logic [p_DEPTH-1:0][p_WIDTH-1:0] sync_q;
  logic [p_WIDTH-1:0][cnt_w-1:0]   cnt_q, cnt_d;
  logic [p_WIDTH-1:0]              f_q, f_d, rise_q, fall_q, flip, s;
  assign s = sync_q[p_DEPTH-1];
  // A channel flips only once its disagreement run has lasted the full filter length;
  // with a single-cycle filter cnt_last is 0, so any disagreement flips at once.
  always_comb begin
    flip  = '0;
    cnt_d = '0;
    for (int k = 0; k < p_WIDTH; k++) begin
      flip[k]  = (s[k] != f_q[k]) && (cnt_q[k] == cnt_last);
      cnt_d[k] = (s[k] == f_q[k] || flip[k]) ? '0 : cnt_q[k] + 1'b1;
    end
  end
  assign f_d = f_q ^ flip;
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      sync_q <= {p_DEPTH{p_INIT_VALUE}};
      f_q    <= p_INIT_VALUE;
      cnt_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync_q <= {sync_q[p_DEPTH-2:0], iwv_input};
      f_q    <= f_d;
      cnt_q  <= cnt_d;
      rise_q <= flip & s;
      fall_q <= flip & ~s;
    end
  end
  assign owv_output  = f_q;
  assign owv_rise    = rise_q;
  assign owv_fall    = fall_q;
  assign ow_any_edge = |(rise_q | fall_q);
endmodule

// File: tb/tb_sync_debounce_edge.sv
// tb_sync_debounce_edge: random and directed checks against a window-based reference model
module tb_sync_debounce_edge;
  localparam int w = 4;
  localparam int depth = 2;
  localparam int filt = 4;
  localparam logic [w-1:0] init = 4'h0;
  logic         iw_clk = 1'b0;
  logic         iw_rst;
  logic [w-1:0] iwv_input;
  logic [w-1:0] owv_output, owv_rise, owv_fall;
  logic         ow_any_edge;
  sync_debounce_edge #(
    .p_WIDTH(w), .p_DEPTH(depth), .p_FILTER_CYCLES(filt), .p_INIT_VALUE(init)
  ) dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst), .iwv_input(iwv_input),
    .owv_output(owv_output), .owv_rise(owv_rise), .owv_fall(owv_fall),
    .ow_any_edge(ow_any_edge)
  );
  always #5 iw_clk = ~iw_clk;
  int n_cmp = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Reference model: history of raw samples gives the synchronised value seen at each edge;
  // a channel flips when every one of the last filt seen values differs from its level and
  // all of them were seen after that channel's previous flip.
  logic [w-1:0] hist[$];
  logic [w-1:0] seen_q[$];
  logic [w-1:0] m_f, m_rise, m_fall;
  int n_edge;
  int last_flip[w];
  int edge_no, first_rise, fall2;
  task automatic model_reset();
    hist = {};
    for (int i = 0; i < depth; i++) hist.push_back(init);
    seen_q = {};
    m_f = init;
    m_rise = '0;
    m_fall = '0;
    n_edge = 0;
    for (int c = 0; c < w; c++) last_flip[c] = 0;
  endtask
  task automatic model_edge(input logic [w-1:0] v);
    logic [w-1:0] seen, flip;
    bit ok;
    seen = hist[hist.size() - depth];
    hist.push_back(v);
    if (hist.size() > 2 * depth) void'(hist.pop_front());
    seen_q.push_back(seen);
    if (seen_q.size() > filt + 1) void'(seen_q.pop_front());
    n_edge++;
    flip = '0;
    for (int c = 0; c < w; c++) begin
      if (n_edge - last_flip[c] >= filt) begin
        ok = 1'b1;
        for (int j = 0; j < filt; j++)
          if (seen_q[seen_q.size() - 1 - j][c] == m_f[c]) ok = 1'b0;
        if (ok) begin
          flip[c] = 1'b1;
          last_flip[c] = n_edge;
        end
      end
    end
    m_rise = flip & seen;
    m_fall = flip & ~seen;
    m_f = m_f ^ flip;
  endtask
  task automatic cyc(input logic [w-1:0] v);
    iwv_input = v;
    @(posedge iw_clk);
    if (!iw_rst) model_edge(v);
    #1;
    chk("out", owv_output, m_f);
    chk("rise", owv_rise, m_rise);
    chk("fall", owv_fall, m_fall);
    chk("any", ow_any_edge, |(m_rise | m_fall));
    if (!iw_rst) edge_no++;
    if (owv_rise != 0 && first_rise == 0) first_rise = edge_no;
    if (owv_fall[2]) fall2++;
  endtask
  task automatic hold(input logic [w-1:0] v, input int n);
    for (int i = 0; i < n; i++) cyc(v);
  endtask
  task automatic mid_rst();
    #2 iw_rst = 1'b1;
    #1;
    model_reset();
    chk("rst_out", owv_output, init);
    chk("rst_rise", owv_rise, 0);
    chk("rst_fall", owv_fall, 0);
    chk("rst_any", ow_any_edge, 0);
  endtask
  task automatic release_rst();
    iw_rst = 1'b0;
    edge_no = 0;
    first_rise = 0;
  endtask
  initial begin
    logic [w-1:0] v;
    iw_rst = 1'b1;
    iwv_input = 4'hF;
    model_reset();
    hold(4'hF, 3);
    release_rst();
    hold(4'hF, 10);
    chk("rst_lat", first_rise, 6);
    hold(4'h0, 8);
    hold(4'h1, 8);
    hold(4'h3, 3);
    hold(4'h1, 8);
    chk("glitch_out1", owv_output[1], 0);
    hold(4'h3, 4);
    hold(4'h1, 8);
    hold(4'h5, 8);
    fall2 = 0;
    hold(4'h1, 2);
    hold(4'h5, 1);
    hold(4'h1, 12);
    chk("fall2_cnt", fall2, 1);
    hold(4'h0, 8);
    hold(4'h9, 8);
    hold(4'h8, 8);
    hold(4'h9, 4);
    mid_rst();
    hold(4'h9, 2);
    release_rst();
    hold(4'h9, 10);
    chk("mid_lat", first_rise, 6);
    v = 4'h9;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < w; c++)
        if ($urandom_range(0, 4) == 0) v[c] = ~v[c];
      cyc(v);
      if ($urandom_range(0, 199) == 0) begin
        mid_rst();
        hold(v, 2);
        release_rst();
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sync_debounce_edge.md
Name: sync_debounce_edge

Overview:
- Multi-channel input conditioner for asynchronous or bouncy signals such as buttons, switches and external strobes.
- Each channel passes through a parametrised synchroniser chain, then a per-channel stability (debounce) filter, then a registered edge detector.
- Supersedes the bare synchroniser chain at all off-chip and cross-domain input points that also need glitch rejection or edge events.

Parameters:
- p_WIDTH, 1: number of independent channels.
- p_DEPTH, 2: synchroniser flops per channel. Minimum 2; elaboration error below that.
- p_FILTER_CYCLES, 1: consecutive clock cycles a new synchronised level must persist before it is accepted. Minimum 1; elaboration error below that. 1 means no filtering.
- p_INIT_VALUE, 0: p_WIDTH-bit reset value of every chain stage and every filtered output, per channel.

Ports:
- iw_clk  input  1  single clock for all logic.
- iw_rst  input  1  asynchronous, active-high reset.
- iwv_input  input  p_WIDTH  raw asynchronous inputs, one bit per channel.
- owv_output  output  p_WIDTH  synchronised, debounced level per channel.
- owv_rise  output  p_WIDTH  one-cycle pulse per channel when owv_output goes 0->1.
- owv_fall  output  p_WIDTH  one-cycle pulse per channel when owv_output goes 1->0.
- ow_any_edge  output  1  OR-reduction of owv_rise | owv_fall.

Behaviour:
- Reset (iw_rst=1, asynchronous, any time including mid-operation):
  - All chain stages = p_INIT_VALUE.
  - owv_output = p_INIT_VALUE.
  - Filter counters = 0.
  - owv_rise = owv_fall = 0, ow_any_edge = 0.
  - Reset release is synchronous in effect. The first active edge after deassertion behaves as normal operation.
  - Reset never produces an edge pulse.
- Synchroniser, per channel:
  - stage[0] <= input bit.
  - stage[k] <= stage[k-1].
  - The synchronised bit s is stage[p_DEPTH-1].
- Filter, per channel:
  - State: filtered bit f (drives owv_output) and counter c.
  - Counter width = clog2(p_FILTER_CYCLES), minimum 1 bit. c never exceeds p_FILTER_CYCLES-1.
  - Each edge, if s == f: c <= 0, f held.
  - Each edge, if s != f and c < p_FILTER_CYCLES-1: c <= c+1, f held.
  - Each edge, if s != f and c == p_FILTER_CYCLES-1: f <= s, c <= 0.
  - With p_FILTER_CYCLES=1, f <= s every edge and c is unused.
  - A disagreement run shorter than p_FILTER_CYCLES cycles is discarded completely. c restarts at 0 on the next disagreement.
- Edge detect, per channel, registered in the same edge that updates f:
  - rise <= (f flips) & s.
  - fall <= (f flips) & ~s.
  - Pulses last exactly one cycle and are coincident with the new owv_output value.
- ow_any_edge: combinational OR over the registered rise/fall vectors. No added latency.
- Latency:
  - An input level stable from before edge E0 (captured by stage[0] at E0) appears on owv_output, with its edge pulse, at edge E0 + p_DEPTH + p_FILTER_CYCLES - 1.
  - Minimum latency is 2 cycles (p_DEPTH=2, p_FILTER_CYCLES=1).
- Channels are fully independent. Simultaneous edges on several channels each pulse in their own bit.
- A post-reset input differing from p_INIT_VALUE is a normal transition. It yields f flip plus a pulse after the latency above.
- A continuously toggling input whose period per level is below p_FILTER_CYCLES never changes owv_output and never pulses.
- No metastability assumptions beyond stage[0]. No combinational path from iwv_input to any output.

Test Plan:
- Reset values: p_WIDTH=4, p_DEPTH=2, p_FILTER_CYCLES=4, p_INIT_VALUE=0.
  - Hold iw_rst=1 with iwv_input=4'hF -> owv_output=0, rise/fall=0 throughout.
  - Release reset -> owv_output=4'hF and owv_rise=4'hF for one cycle, at edge 5 after the first post-reset capture.
- Debounce accept: same config, from steady 0 drive ch0=1 before edge E0 -> owv_output[0]=1 and owv_rise[0]=1 at edge E0+5. owv_rise[0]=0 at E0+6. ow_any_edge pulses once.
- Glitch reject: same config, ch1 high for exactly 3 cycles then low -> owv_output[1] stays 0, no rise/fall pulses. A following 4-cycle high pulse is accepted.
- Fall and mid-run restart: ch2 steady 1, then low 2 cycles, high 1 cycle, low 4 cycles -> exactly one owv_fall[2] pulse, 5 edges after the start of the final 4-cycle low run.
- Simultaneous events: ch0 and ch3 rise together -> owv_rise=4'b1001 in a single cycle, ow_any_edge=1 for that cycle only.
- Reset mid-operation: assert iw_rst between edges while ch0 counter is at 2 -> outputs immediately 0 and counter cleared. After release with input still 1, a full 5-edge latency is required again before the rise pulse.
